muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV64M multiply/divide unit between the register file read ports and its write port. It takes `read_data1`/`read_data2` operands and a destination index, runs a radix-2 multiply or restoring divide over multiple cycles, then returns a one-cycle writeback (`result`, `rd_out`, `reg_write`) that drives the register file's `write_data`/`rd`/`reg_write` inputs.

## Interface
- `XLEN`, 64: operand and result width (fixed at 64; RV64).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted on a rising edge when `busy`=0.
- `op`  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `word`  in  1  W-variant select (see Configuration).
- `rs1_data`  in  64  operand A / dividend.
- `rs2_data`  in  64  operand B / divisor.
- `rd_in`  in  5  destination register index.
- `busy`  out  1  iteration in progress; `start` is ignored.
- `done`  out  1  one-cycle result-valid strobe.
- `result`  out  64  result, valid while `done`=1.
- `rd_out`  out  5  captured `rd_in`, valid while `done`=1.
- `reg_write`  out  1  `done` && `rd_out`!=0.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with `busy`, `done`, and `reg_write` at 0, and `result` and `rd_out` at 0. The internal counter, accumulator, and operands are cleared.
- Capture happens when `start`=1 in IDLE or DONE. The block latches `op`, `word`, `rd_in`, and the operand magnitudes, plus the result-sign flags.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Datapath:
  - Iterations run on magnitudes. The result is negated at completion when the sign flag is set.
  - REM takes the dividend's sign.
  - The multiplier keeps a 128-bit product. MUL returns bits [63:0]; the MULH* ops return bits [127:64].
- RUN performs one iteration per edge, N iterations in total: N=64, or N=32 for W ops. After the last iteration the block goes to DONE.
- Divide-by-zero skips RUN and goes straight to DONE:
  - DIV/DIVU return 0xFFFF_FFFF_FFFF_FFFF.
  - REM/REMU return the dividend.
- Signed overflow (dividend 0x8000_0000_0000_0000, divisor −1) also skips RUN:
  - DIV returns the dividend.
  - REM returns 0.
- DONE lasts one cycle. The next state is IDLE, or RUN if `start`=1 (back-to-back operation).
- `start` during RUN is ignored; no queueing.
- `rd_in`=0: the operation completes and `done` pulses, but `reg_write` stays 0.

## Timing
- Capture edge = E0.
- Normal operation:
  - `busy`=1 from E0 to EN.
  - `done`, `reg_write`, `result`, and `rd_out` are registered. They go high at EN and stay valid until EN+1.
  - Latency is 64 edges (32 for W).
- Special cases (div-by-zero, overflow): `busy` stays 0 and `done` is high from E1 to E2.
- `result` and `rd_out` hold their last values outside `done`. The consumer must qualify on `done`.
- Asynchronous reset mid-RUN abandons the operation immediately: all outputs go to 0 and no `done` is issued.
- `start` in the DONE cycle: the current result is still delivered, and the new operation's E0 is that same edge.

## Configuration
- `MULDIV_WORD_OPS_EN` defined:
  - `word`=1 selects MULW, DIVW, DIVUW, REMW, or REMUW.
  - Operands are the low 32 bits, sign- or zero-extended per op, with N=32.
  - The 32-bit result is sign-extended from bit 31.
  - `word`=1 with op 001–011 executes as MULW.
- Not defined:
  - `word` is ignored and treated as 0.
  - W logic is not synthesised, and the counter is 64-only.

## Test plan
- MUL rs1=7, rs2=6, rd=5 → `done`/`reg_write` high exactly 64 edges after capture; `result`=0x2A, `rd_out`=5.
- MULH and MULHU with rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2:
  - MULH → 0xFFFF_FFFF_FFFF_FFFF.
  - MULHU → 0x1.
  - MULHSU with rs2=2 → 0xFFFF_FFFF_FFFF_FFFF.
- Signed divide and remainder of −7 by 2:
  - DIV rs1=−7, rs2=2 → 0xFFFF_FFFF_FFFF_FFFD.
  - REM rs1=−7, rs2=2 → 0xFFFF_FFFF_FFFF_FFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide-by-zero and overflow, each with `done` one edge after capture and `busy` never 1:
  - DIVU 5/0 → 0xFFFF_FFFF_FFFF_FFFF.
  - REM 5/0 → 5.
  - DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000.
  - REM 0x8000_0000_0000_0000 / −1 → 0.
- Control sequence:
  - `start` pulsed at iteration 10 with different operands → ignored; the first result is delivered unchanged.
  - `reset` at iteration 30 → all outputs 0 and no `done`.
  - rd=0 → `done`=1 with `reg_write`=0.
  - Back-to-back `start` in the DONE cycle → second result arrives 64 edges later.
- With `MULDIV_WORD_OPS_EN` defined:
  - MULW 0x7FFF_FFFF×2 → 0xFFFF_FFFF_FFFF_FFFE after 32 edges.
  - DIVW 0x1_0000_0006 / 3 → 2.
- With `MULDIV_WORD_OPS_EN` undefined: the same MULW stimulus → the 64-bit MUL result 0xFFFF_FFFE after 64 edges.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Optional W-variant support (MULW/DIVW/DIVUW/REMW/REMUW) is enabled by defining MULDIV_WORD_OPS_EN.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        word_q, word_d;
    logic [4:0]  rd_q, rd_d;
    logic        neg_q, neg_d;
    logic        special_q, special_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] a_q, a_d;
    logic [63:0] hi_q, hi_d;
    logic [63:0] lo_q, lo_d;
    logic        done_q, reg_write_q;
    logic [63:0] result_q;
    logic [4:0]  rd_out_q;

    logic        word_s, capture_s, finish_s, busy_s;
    logic        w_mul_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic        div_zero_s, ovf_s, special_s;
    logic [63:0] a_full_s, b_full_s, a_mag_s, b_mag_s, spec_res_s, int_min_s;
    logic [5:0]  cnt_load_s;
    logic [64:0] mul_sum_s, div_shift_s;
    logic [63:0] div_sub_s, it_hi_s, it_lo_s;
    logic [127:0] prod_s, prod_sgn_s;
    logic [63:0] div_val_s, div_sgn_s, raw_s, result_s;

`ifdef MULDIV_WORD_OPS_EN
    assign word_s     = word;
    assign cnt_load_s = word ? 6'd31 : 6'd63;
`else
    assign word_s     = word & 1'b0;
    assign cnt_load_s = 6'd63;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_RUN : S_IDLE;
            S_RUN:   state_d = (special_q || cnt_q == 6'd0) ? S_DONE : S_RUN;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output decode; special cases pass through RUN for one edge without raising busy.
    always_comb begin
        capture_s = 1'b0;
        busy_s    = 1'b0;
        finish_s  = 1'b0;
        case (state_q)
            S_IDLE:  capture_s = start;
            S_RUN: begin
                busy_s   = ~special_q;
                finish_s = special_q || (cnt_q == 6'd0);
            end
            S_DONE:  capture_s = start;
            default: capture_s = 1'b0;
        endcase
    end

    // Operand preparation: width selection, signedness, magnitudes and special-case detection.
    always_comb begin
        w_mul_s    = word_s & ~op[2];
        a_signed_s = ~w_mul_s & ((op == 3'b000) | (op == 3'b001) | (op == 3'b010) |
                                 (op == 3'b100) | (op == 3'b110));
        b_signed_s = ~w_mul_s & ((op == 3'b000) | (op == 3'b001) | (op == 3'b100) |
                                 (op == 3'b110));
        if (word_s) begin
            a_full_s  = {{32{a_signed_s & rs1_data[31]}}, rs1_data[31:0]};
            b_full_s  = {{32{b_signed_s & rs2_data[31]}}, rs2_data[31:0]};
            int_min_s = 64'hFFFF_FFFF_8000_0000;
        end else begin
            a_full_s  = rs1_data;
            b_full_s  = rs2_data;
            int_min_s = 64'h8000_0000_0000_0000;
        end
        a_neg_s    = a_signed_s & a_full_s[63];
        b_neg_s    = b_signed_s & b_full_s[63];
        a_mag_s    = a_neg_s ? (~a_full_s + 64'd1) : a_full_s;
        b_mag_s    = b_neg_s ? (~b_full_s + 64'd1) : b_full_s;
        div_zero_s = op[2] & (b_full_s == 64'd0);
        ovf_s      = op[2] & ~op[0] & (a_full_s == int_min_s) & (b_full_s == 64'hFFFF_FFFF_FFFF_FFFF);
        special_s  = div_zero_s | ovf_s;
        if (div_zero_s) begin
            spec_res_s = op[1] ? a_full_s : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            spec_res_s = op[1] ? 64'd0 : a_full_s;
        end
    end

    // One multiply or divide iteration on the current accumulator.
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : 65'd0);
        div_shift_s = {hi_q, lo_q[63]};
        div_sub_s   = div_shift_s[63:0] - a_q;
        if (op_q[2]) begin
            if (div_shift_s >= {1'b0, a_q}) begin
                it_hi_s = div_sub_s;
                it_lo_s = {lo_q[62:0], 1'b1};
            end else begin
                it_hi_s = div_shift_s[63:0];
                it_lo_s = {lo_q[62:0], 1'b0};
            end
        end else begin
            it_hi_s = mul_sum_s[64:1];
            it_lo_s = {mul_sum_s[0], lo_q[63:1]};
        end
    end

    // Result formatting: sign fix-up, high/low selection and W sign-extension.
    always_comb begin
        prod_s     = {it_hi_s, it_lo_s};
        prod_sgn_s = neg_q ? (~prod_s + 128'd1) : prod_s;
        div_val_s  = op_q[1] ? it_hi_s : it_lo_s;
        div_sgn_s  = neg_q ? (~div_val_s + 64'd1) : div_val_s;
        if (special_q) begin
            raw_s = lo_q;
        end else if (op_q[2]) begin
            raw_s = div_sgn_s;
        end else if (word_q) begin
            raw_s = {32'd0, it_lo_s[63:32]};
        end else if (op_q == 3'b000) begin
            raw_s = prod_sgn_s[63:0];
        end else begin
            raw_s = prod_sgn_s[127:64];
        end
        result_s = word_q ? {{32{raw_s[31]}}, raw_s[31:0]} : raw_s;
    end

    // Datapath next-state: capture operands, or iterate while running.
    always_comb begin
        op_d      = op_q;
        word_d    = word_q;
        rd_d      = rd_q;
        neg_d     = neg_q;
        special_d = special_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (capture_s) begin
            op_d      = op;
            word_d    = word_s;
            rd_d      = rd_in;
            neg_d     = (op[2] & op[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
            special_d = special_s;
            cnt_d     = cnt_load_s;
            hi_d      = 64'd0;
            if (special_s) begin
                a_d  = 64'd0;
                lo_d = spec_res_s;
            end else if (op[2]) begin
                a_d  = b_mag_s;
                lo_d = word_s ? {a_mag_s[31:0], 32'd0} : a_mag_s;
            end else begin
                a_d  = a_mag_s;
                lo_d = b_mag_s;
            end
        end else if (busy_s) begin
            cnt_d = cnt_q - 6'd1;
            hi_d  = it_hi_s;
            lo_d  = it_lo_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= 3'd0;
            word_q    <= 1'b0;
            rd_q      <= 5'd0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            cnt_q     <= 6'd0;
            a_q       <= 64'd0;
            hi_q      <= 64'd0;
            lo_q      <= 64'd0;
        end else begin
            op_q      <= op_d;
            word_q    <= word_d;
            rd_q      <= rd_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Writeback registers; result and rd_out hold between completions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q      <= 1'b0;
            reg_write_q <= 1'b0;
            result_q    <= 64'd0;
            rd_out_q    <= 5'd0;
        end else if (finish_s) begin
            done_q      <= 1'b1;
            reg_write_q <= (rd_q != 5'd0);
            result_q    <= result_s;
            rd_out_q    <= rd_q;
        end else begin
            done_q      <= 1'b0;
            reg_write_q <= 1'b0;
        end
    end

    assign busy      = busy_s;
    assign done      = done_q;
    assign reg_write = reg_write_q;
    assign result    = result_q;
    assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; W-op vectors follow MULDIV_WORD_OPS_EN.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        word;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [4:0]  rd_out;
    logic        reg_write;

    int checks;
    int errors;

    muldiv_unit #(.XLEN(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .word     (word),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out),
        .reg_write(reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request at the negedge; returns busy sampled just after the capture edge.
    task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, output logic busy_e0);
        @(negedge clk);
        op = o; word = w; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_e0 = busy;
    endtask

    // Count edges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                          input int lat, input logic [63:0] exp);
        logic b0;
        int   n;
        issue(o, w, a, b, rd, b0);
        wait_done(n);
        check_eq({tag, " latency"}, 64'(n), 64'(lat));
        check_eq({tag, " result"}, result, exp);
        check_eq({tag, " rd_out"}, {59'd0, rd_out}, {59'd0, rd});
        check_eq({tag, " reg_write"}, {63'd0, reg_write}, {63'd0, (rd != 5'd0)});
        check_eq({tag, " busy"}, {63'd0, b0}, {63'd0, (lat > 1)});
        @(posedge clk);
        #1;
        check_eq({tag, " done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic b0;
        int   n;
        int   dcount;
        checks = 0;
        errors = 0;
        reset = 1'b1; start = 1'b0; op = 3'd0; word = 1'b0;
        rs1_data = 64'd0; rs2_data = 64'd0; rd_in = 5'd0;
        #1;
        check_eq("rst busy", {63'd0, busy}, 64'd0);
        check_eq("rst done", {63'd0, done}, 64'd0);
        check_eq("rst result", result, 64'd0);
        check_eq("rst rd_out", {59'd0, rd_out}, 64'd0);
        check_eq("rst reg_write", {63'd0, reg_write}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul",    3'b000, 1'b0, 64'd7, 64'd6, 5'd5, 64, 64'h2A);
        run_op("mulh",   3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 64, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulhu",  3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64, 64'h1);
        run_op("mulhsu", 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div",    3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem",    3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("divu",   3'b101, 1'b0, 64'd100, 64'd7, 5'd7, 64, 64'd14);
        run_op("remu",   3'b111, 1'b0, 64'd100, 64'd7, 5'd8, 64, 64'd2);
        run_op("divu_z", 3'b101, 1'b0, 64'd5, 64'd0, 5'd10, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("rem_z",  3'b110, 1'b0, 64'd5, 64'd0, 5'd11, 1, 64'd5);
        run_op("div_ov", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 1,
               64'h8000_0000_0000_0000);
        run_op("rem_ov", 3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 1, 64'd0);
        run_op("rd0",    3'b000, 1'b0, 64'd3, 64'd3, 5'd0, 64, 64'd9);

        // start during RUN must be ignored
        issue(3'b000, 1'b0, 64'd7, 64'd6, 5'd5, b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        op = 3'b101; rs1_data = 64'd100; rs2_data = 64'd7; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check_eq("ign latency", 64'(n + 11), 64'd64);
        check_eq("ign result", result, 64'h2A);
        check_eq("ign rd_out", {59'd0, rd_out}, 64'd5);
        @(posedge clk);
        #1;

        // back-to-back start in the DONE cycle
        issue(3'b000, 1'b0, 64'd7, 64'd6, 5'd5, b0);
        wait_done(n);
        check_eq("b2b first latency", 64'(n), 64'd64);
        check_eq("b2b first result", result, 64'h2A);
        issue(3'b101, 1'b0, 64'd100, 64'd7, 5'd9, b0);
        check_eq("b2b done drop", {63'd0, done}, 64'd0);
        check_eq("b2b busy", {63'd0, b0}, 64'd1);
        wait_done(n);
        check_eq("b2b second latency", 64'(n), 64'd64);
        check_eq("b2b second result", result, 64'd14);
        check_eq("b2b second rd_out", {59'd0, rd_out}, 64'd9);
        @(posedge clk);
        #1;

        // asynchronous reset mid-iteration
        issue(3'b101, 1'b0, 64'd100, 64'd7, 5'd9, b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("arst busy", {63'd0, busy}, 64'd0);
        check_eq("arst done", {63'd0, done}, 64'd0);
        check_eq("arst result", result, 64'd0);
        check_eq("arst rd_out", {59'd0, rd_out}, 64'd0);
        check_eq("arst reg_write", {63'd0, reg_write}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check_eq("arst no done", 64'(dcount), 64'd0);

`ifdef MULDIV_WORD_OPS_EN
        run_op("mulw", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd14, 32, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("divw", 3'b100, 1'b1, 64'h1_0000_0006, 64'd3, 5'd15, 32, 64'd2);
`else
        run_op("mulw_off", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd14, 64, 64'hFFFF_FFFE);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
